// File: rtl/uart_rx_fifo_gen.sv
// Receive-side word FIFO with level flags, sticky overflow/underflow and a selectable read mode.
// Registered read gives data one cycle after rd_en; FWFT presents the head word whenever not empty.
module uart_rx_fifo_gen #(
  parameter int DBITS     = 8,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DBITS-1:0]  wr_data,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DBITS-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_rx_fifo_gen: DEPTH must be a power of 2 and >= 4");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
      $error("uart_rx_fifo_gen: AF_THRESH must be in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
      $error("uart_rx_fifo_gen: AE_THRESH must be in 0..DEPTH-1");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LVL_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LVL_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_AF  = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0]   LVL_AE  = (ADDR_W + 1)'(AE_THRESH);

  logic [DBITS-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DBITS-1:0]  rd_data_q;
  logic              rd_valid_q;
  logic              rd_ok;
  logic              wr_ok;

  assign empty        = (level == '0);
  assign full         = (level == LVL_MAX);
  assign almost_full  = (level >= LVL_AF);
  assign almost_empty = (level <= LVL_AE);

  // A write into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // In FWFT mode an empty FIFO keeps showing the last popped word rather than stale memory.
  assign rd_data  = ((FWFT != 0) && !empty) ? mem[rd_ptr] : rd_data_q;
  assign rd_valid = (FWFT != 0) ? !empty : rd_valid_q;

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        rd_data_q <= mem[rd_ptr];
      end
      rd_valid_q <= rd_ok;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      // Set beats clear so an error in the clearing cycle is not lost.
      if (wr_en && !wr_ok) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_gen.sv
// Directed bench for uart_rx_fifo_gen: registered-read instance plus an FWFT instance.
module tb_uart_rx_fifo_gen;

  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  logic       a_flush = 0, a_wr_en = 0, a_rd_en = 0, a_clr_err = 0;
  logic [7:0] a_wr_data = 0;
  logic [7:0] a_rd_data;
  logic       a_rd_valid, a_empty, a_full, a_af, a_ae, a_ovf, a_unf;
  logic [5:0] a_level;

  logic       b_flush = 0, b_wr_en = 0, b_rd_en = 0, b_clr_err = 0;
  logic [7:0] b_wr_data = 0;
  logic [7:0] b_rd_data;
  logic       b_rd_valid, b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
  logic [5:0] b_level;

  uart_rx_fifo_gen #(.DBITS(8), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(0)) u_dut (
    .clk(clk), .areset(areset), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .clr_err(a_clr_err), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .empty(a_empty), .full(a_full), .almost_full(a_af), .almost_empty(a_ae),
    .level(a_level), .overflow(a_ovf), .underflow(a_unf)
  );

  uart_rx_fifo_gen #(.DBITS(8), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(1)) u_dut_fwft (
    .clk(clk), .areset(areset), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .clr_err(b_clr_err), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .empty(b_empty), .full(b_full), .almost_full(b_af), .almost_empty(b_ae),
    .level(b_level), .overflow(b_ovf), .underflow(b_unf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst_level", a_level, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_ae", a_ae, 1);
    check("rst_af", a_af, 0);
    check("rst_rd_valid", a_rd_valid, 0);
    check("rst_rd_data", a_rd_data, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_unf", a_unf, 0);
    #10 areset = 1'b1;
    step();

    // fill 0x00..0x1F
    for (int i = 0; i < 32; i++) begin
      a_wr_en = 1; a_wr_data = 8'(i);
      step();
      check($sformatf("fill_level_%0d", i), a_level, i + 1);
      check($sformatf("fill_af_%0d", i), a_af, (i + 1 >= 28) ? 1 : 0);
    end
    check("fill_full", a_full, 1);

    // overflow at full
    a_wr_data = 8'hAA;
    step();
    check("ovf_flag", a_ovf, 1);
    check("ovf_level", a_level, 32);
    a_wr_en = 0; a_clr_err = 1;
    step();
    a_clr_err = 0;
    check("ovf_clear", a_ovf, 0);

    // simultaneous write/read at full
    a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'h55;
    step();
    a_wr_en = 0;
    check("simfull_level", a_level, 32);
    check("simfull_data", a_rd_data, 8'h00);
    check("simfull_valid", a_rd_valid, 1);
    for (int i = 0; i < 32; i++) begin
      step();
      check($sformatf("drain_data_%0d", i), a_rd_data, (i < 31) ? i + 1 : 8'h55);
      check($sformatf("drain_valid_%0d", i), a_rd_valid, 1);
    end
    a_rd_en = 0;
    step();
    check("drain_valid_drop", a_rd_valid, 0);
    check("drain_empty", a_empty, 1);
    check("drain_hold", a_rd_data, 8'h55);
    check("drain_unf", a_unf, 0);

    // simultaneous write/read at empty
    a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'h3C;
    step();
    a_wr_en = 0;
    check("simempty_unf", a_unf, 1);
    check("simempty_level", a_level, 1);
    check("simempty_valid", a_rd_valid, 0);
    step();
    a_rd_en = 0;
    check("simempty_data", a_rd_data, 8'h3C);
    check("simempty_rdvalid", a_rd_valid, 1);
    a_clr_err = 1;
    step();
    a_clr_err = 0;
    check("unf_clear", a_unf, 0);
    check("one_cycle_valid", a_rd_valid, 0);

    // 40 interleaved transfers crossing address 31 -> 0
    for (int i = 0; i < 40; i++) begin
      a_wr_en = 1; a_wr_data = 8'(8'h40 + i); a_rd_en = (i > 0);
      step();
      check($sformatf("wrap_level_%0d", i), a_level, 1);
      if (i > 0) check($sformatf("wrap_data_%0d", i), a_rd_data, 8'h40 + i - 1);
    end
    a_wr_en = 0; a_rd_en = 1;
    step();
    a_rd_en = 0;
    check("wrap_last", a_rd_data, 8'h67);
    check("wrap_empty", a_empty, 1);

    // flush with level 5, colliding with wr/rd
    for (int i = 0; i < 5; i++) begin
      a_wr_en = 1; a_wr_data = 8'(8'h90 + i);
      step();
    end
    check("pre_flush_level", a_level, 5);
    a_flush = 1; a_rd_en = 1; a_wr_data = 8'hEE;
    step();
    a_flush = 0; a_rd_en = 0; a_wr_en = 0;
    check("flush_level", a_level, 0);
    check("flush_valid", a_rd_valid, 0);
    check("flush_rd_data", a_rd_data, 8'h67);
    check("flush_unf", a_unf, 0);
    a_wr_en = 1; a_wr_data = 8'hA5;
    step();
    a_wr_en = 0; a_rd_en = 1;
    step();
    a_rd_en = 0;
    check("post_flush_data", a_rd_data, 8'hA5);

    // async reset mid-burst
    a_wr_en = 1;
    for (int i = 0; i < 3; i++) begin
      a_wr_data = 8'(8'hC0 + i);
      step();
    end
    a_rd_en = 1;
    step();
    check("burst_valid", a_rd_valid, 1);
    #2 areset = 1'b0;
    #1;
    check("arst_level", a_level, 0);
    check("arst_valid", a_rd_valid, 0);
    check("arst_data", a_rd_data, 0);
    a_wr_en = 0; a_rd_en = 0;
    step();
    #2 areset = 1'b1;
    a_wr_en = 1; a_wr_data = 8'h11;
    step();
    a_wr_en = 0;
    check("post_rst_level", a_level, 1);
    a_rd_en = 1;
    step();
    a_rd_en = 0;
    check("post_rst_data", a_rd_data, 8'h11);

    // FWFT instance
    check("fwft_empty0", b_empty, 1);
    check("fwft_valid0", b_rd_valid, 0);
    b_wr_en = 1; b_wr_data = 8'h81;
    step();
    b_wr_en = 0;
    check("fwft_valid", b_rd_valid, 1);
    check("fwft_data", b_rd_data, 8'h81);
    b_rd_en = 1;
    step();
    b_rd_en = 0;
    check("fwft_pop_empty", b_empty, 1);
    check("fwft_pop_valid", b_rd_valid, 0);
    b_wr_en = 1; b_wr_data = 8'h01;
    step();
    b_wr_data = 8'h02;
    step();
    b_wr_en = 0;
    check("fwft_head1", b_rd_data, 8'h01);
    b_rd_en = 1;
    step();
    b_rd_en = 0;
    check("fwft_head2", b_rd_data, 8'h02);
    check("fwft_level", b_level, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
